// File: rtl/video_timing_gen_pkg.sv
// Shared raster types and constants for the composite video timing block.
// Line-type classification lives here so every consumer agrees on it.
package video_timing_gen_pkg;

  typedef enum logic [1:0] {
    LT_BROAD  = 2'd0,
    LT_EQ     = 2'd1,
    LT_NORMAL = 2'd2
  } line_type_e;

  localparam int PIXELS_PER_LINE = 256;
  localparam int VISIBLE_LINES   = 256;

  // Line type carried by line v of the raster.
  function automatic line_type_e classify_line(
    input int unsigned v,
    input int unsigned broad_end,
    input int unsigned eq_pre_end,
    input int unsigned eq_post
  );
    if (v < broad_end) begin
      return LT_BROAD;
    end
    if ((v < eq_pre_end) || (v >= eq_post)) begin
      return LT_EQ;
    end
    return LT_NORMAL;
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Master raster timing: H/V counters, line-type FSM and registered decode of
// composite sync, blanking, burst gate and the pixel-strobe interface.
module video_timing_gen
  import video_timing_gen_pkg::*;
#(
  parameter int H_TOTAL       = 3200,
  parameter int H_HALF        = 1600,
  parameter int H_SYNC_LEN    = 235,
  parameter int H_EQ_LEN      = 117,
  parameter int H_BURST_START = 280,
  parameter int H_BURST_LEN   = 113,
  parameter int H_VIS_START   = 650,
  parameter int CLK_PER_PIXEL = 9,
  parameter int V_TOTAL       = 312,
  parameter int V_BROAD_END   = 3,
  parameter int V_EQ_PRE_END  = 5,
  parameter int V_EQ_POST     = 310,
  parameter int V_VIS_START   = 40
) (
  input  logic       clk,
  input  logic       reset,
  output logic       newline,
  output logic       newpixel,
  output logic       visible_window,
  output logic [7:0] video_y,
  output logic       frame_start,
  output logic       sync,
  output logic       blank,
  output logic       burst_window
);

  localparam int HW        = $clog2(H_TOTAL);
  localparam int VW        = $clog2(V_TOTAL);
  localparam int PW        = (CLK_PER_PIXEL > 1) ? $clog2(CLK_PER_PIXEL) : 1;
  localparam int H_VIS_END = H_VIS_START + PIXELS_PER_LINE * CLK_PER_PIXEL;
  localparam int V_VIS_END = V_VIS_START + VISIBLE_LINES;

  if (H_VIS_END > H_TOTAL) begin : g_chk_hvis
    $error("video_timing_gen: active video overruns the line");
  end
  if (V_VIS_END > V_EQ_POST) begin : g_chk_vvis
    $error("video_timing_gen: visible lines overlap post-equalising lines");
  end
  if (H_BURST_START + H_BURST_LEN > H_VIS_START) begin : g_chk_burst
    $error("video_timing_gen: burst gate overlaps active video");
  end
  if (CLK_PER_PIXEL < 2) begin : g_chk_cpp
    $error("video_timing_gen: CLK_PER_PIXEL must be at least 2");
  end

  logic [HW-1:0] h_reg, h_next;
  logic [VW-1:0] v_reg, v_next;
  logic [PW-1:0] pix_reg, pix_next;
  line_type_e    lt_reg, lt_next;
  logic          h_wrap;

  int unsigned h_u, v_u, hn_u, vn_u, pix_u;

  assign h_u   = 32'(h_reg);
  assign v_u   = 32'(v_reg);
  assign hn_u  = 32'(h_next);
  assign vn_u  = 32'(v_next);
  assign pix_u = 32'(pix_reg);

  // Counter advance; the pixel divider is phase-locked to the window start.
  always_comb begin
    h_wrap   = (h_u == H_TOTAL - 1);
    h_next   = h_wrap ? '0 : h_reg + HW'(1);
    v_next   = v_reg;
    pix_next = pix_reg + PW'(1);
    if (h_wrap) begin
      v_next = (v_u == V_TOTAL - 1) ? '0 : v_reg + VW'(1);
    end
    if (hn_u == H_VIS_START) begin
      pix_next = '0;
    end else if (pix_u == CLK_PER_PIXEL - 1) begin
      pix_next = '0;
    end
  end

  // Line-type FSM: the new type is taken from the line being entered.
  always_comb begin
    lt_next = lt_reg;
    if (h_wrap) begin
      lt_next = classify_line(vn_u, V_BROAD_END, V_EQ_PRE_END, V_EQ_POST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_reg   <= '0;
      v_reg   <= '0;
      pix_reg <= '0;
      lt_reg  <= LT_BROAD;
    end else begin
      h_reg   <= h_next;
      v_reg   <= v_next;
      pix_reg <= pix_next;
      lt_reg  <= lt_next;
    end
  end

  logic       line_start_d;
  logic       frame_d;
  logic       sync_d;
  logic       vis_line_d;
  logic       window_d;
  logic       burst_d;
  logic       newpixel_d;
  logic [7:0] video_y_d;

  always_comb begin
    line_start_d = (h_u == 0);
    frame_d      = line_start_d && (v_u == 0);
    vis_line_d   = (v_u >= V_VIS_START) && (v_u < V_VIS_END);
    window_d     = (lt_reg == LT_NORMAL) && vis_line_d &&
                   (h_u >= H_VIS_START) && (h_u < H_VIS_END);
    burst_d      = (lt_reg == LT_NORMAL) && (h_u >= H_BURST_START) &&
                   (h_u < H_BURST_START + H_BURST_LEN);
    newpixel_d   = window_d && (pix_reg == '0);

    sync_d = 1'b0;
    case (lt_reg)
      LT_NORMAL: sync_d = (h_u < H_SYNC_LEN);
      LT_EQ:     sync_d = (h_u < H_EQ_LEN) ||
                          ((h_u >= H_HALF) && (h_u < H_HALF + H_EQ_LEN));
      LT_BROAD:  sync_d = (h_u < H_HALF - H_SYNC_LEN) ||
                          ((h_u >= H_HALF) && (h_u < H_TOTAL - H_SYNC_LEN));
      default:   sync_d = 1'b0;
    endcase

    // The line index is latched once per line so it is stable for consumers.
    video_y_d = video_y;
    if (line_start_d) begin
      video_y_d = vis_line_d ? 8'(v_u - V_VIS_START) : 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      newline        <= 1'b0;
      frame_start    <= 1'b0;
      sync           <= 1'b0;
      blank          <= 1'b0;
      visible_window <= 1'b0;
      burst_window   <= 1'b0;
      newpixel       <= 1'b0;
      video_y        <= 8'd0;
    end else begin
      newline        <= line_start_d;
      frame_start    <= frame_d;
      sync           <= sync_d;
      blank          <= !window_d;
      visible_window <= window_d;
      burst_window   <= burst_d;
      newpixel       <= newpixel_d;
      video_y        <= video_y_d;
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Checks the raster generator cycle by cycle against an arithmetic model of
// the raster, on a compact geometry so whole frames simulate quickly.
module tb_video_timing_gen;

  localparam int HT   = 530;
  localparam int HH   = 265;
  localparam int HS   = 8;
  localparam int HEQ  = 4;
  localparam int HBS  = 10;
  localparam int HBL  = 6;
  localparam int HVS  = 18;
  localparam int CPP  = 2;
  localparam int VT   = 262;
  localparam int VBE  = 2;
  localparam int VEPE = 3;
  localparam int VEP  = 260;
  localparam int VVS  = 4;

  localparam int PIX_LINE = VVS + 10;
  localparam int MID_LINE = 20;
  localparam int MAX_BAD  = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic       newline, newpixel, visible_window, frame_start, sync, blank, burst_window;
  logic [7:0] video_y;

  video_timing_gen #(
    .H_TOTAL(HT), .H_HALF(HH), .H_SYNC_LEN(HS), .H_EQ_LEN(HEQ),
    .H_BURST_START(HBS), .H_BURST_LEN(HBL), .H_VIS_START(HVS),
    .CLK_PER_PIXEL(CPP), .V_TOTAL(VT), .V_BROAD_END(VBE),
    .V_EQ_PRE_END(VEPE), .V_EQ_POST(VEP), .V_VIS_START(VVS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .newline(newline),
    .newpixel(newpixel),
    .visible_window(visible_window),
    .video_y(video_y),
    .frame_start(frame_start),
    .sync(sync),
    .blank(blank),
    .burst_window(burst_window)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int pos;
  int last_nl, last_fs, fs_count;
  int win_cnt, np_cnt, last_np;
  logic prev_vis;

  function automatic logic [14:0] observed();
    return {newline, frame_start, sync, blank, burst_window, visible_window, newpixel, video_y};
  endfunction

  // Expected outputs for raster position p (clocks since the counters started).
  function automatic logic [14:0] model(input int p);
    int h, v;
    logic broad, eq, normal, vis_line, vis, np, sy, bu;
    logic [7:0] vy;
    h        = p % HT;
    v        = (p / HT) % VT;
    broad    = (v < VBE);
    eq       = !broad && ((v < VEPE) || (v >= VEP));
    normal   = !broad && !eq;
    if (normal)  sy = (h < HS);
    else if (eq) sy = (h < HEQ) || ((h >= HH) && (h < HH + HEQ));
    else         sy = (h < HH - HS) || ((h >= HH) && (h < HT - HS));
    vis_line = (v >= VVS) && (v < VVS + 256);
    vis      = normal && vis_line && (h >= HVS) && (h < HVS + 256 * CPP);
    np       = vis && (((h - HVS) % CPP) == 0);
    bu       = normal && (h >= HBS) && (h < HBS + HBL);
    vy       = vis_line ? 8'(v - VVS) : 8'd0;
    return {h == 0, (h == 0) && (v == 0), sy, !vis, bu, vis, np, vy};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h pos=%0d", tag, obs, exp, pos);
    end
  endtask

  task automatic restart_trackers();
    pos      = 0;
    last_nl  = -1;
    last_fs  = -1;
    fs_count = 0;
    last_np  = -1;
    win_cnt  = 0;
    np_cnt   = 0;
    prev_vis = 1'b0;
  endtask

  // One clock: compare every output with the model, plus interval bookkeeping.
  task automatic tick();
    int h, v;
    @(posedge clk);
    @(negedge clk);
    h = pos % HT;
    v = (pos / HT) % VT;
    chk("raster", 32'(observed()), 32'(model(pos)));
    if (newline) begin
      if (last_nl >= 0) chk("newline_spacing", pos - last_nl, HT);
      last_nl = pos;
    end
    if (frame_start) begin
      if (last_fs >= 0) chk("frame_period", pos - last_fs, HT * VT);
      last_fs = pos;
      fs_count++;
    end
    if (v == PIX_LINE) begin
      if (h == 0) begin
        win_cnt = 0;
        np_cnt  = 0;
        last_np = -1;
      end
      if (visible_window) win_cnt++;
      if (newpixel) begin
        if (last_np >= 0) chk("pixel_spacing", pos - last_np, CPP);
        else              chk("first_pixel_on_rise", {30'd0, prev_vis, visible_window}, 32'd1);
        last_np = pos;
        np_cnt++;
      end
      if (h == HVS) chk("video_y_line", video_y, PIX_LINE - VVS);
      if (h == HT - 1) begin
        chk("window_len", win_cnt, 256 * CPP);
        chk("pixel_count", np_cnt, 256);
      end
    end
    prev_vis = visible_window;
    pos++;
  endtask

  task automatic run_until(input int limit);
    while ((pos < limit) && (bad < MAX_BAD)) tick();
  endtask

  initial begin
    int mid_h, extra;
    reset = 1'b1;
    restart_trackers();

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(observed()), 32'd0);
    $display("step: reset held 5 clocks");

    reset = 1'b0;
    tick();
    chk("first_cycle_flags", {29'd0, newline, frame_start, sync}, 32'd7);
    chk("first_cycle_window", {30'd0, visible_window, newpixel}, 32'd0);

    mid_h = $urandom_range(1, HT - 2);
    run_until(MID_LINE * HT + mid_h);
    $display("step: ran to line %0d h=%0d", MID_LINE, mid_h);

    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midline_reset_outputs", 32'(observed()), 32'd0);
    reset = 1'b0;
    restart_trackers();
    $display("step: one-clock reset applied mid-line");

    extra = $urandom_range(1, HT);
    run_until(HT * VT + HT + extra);
    chk("frame_start_count", fs_count, 2);
    $display("step: full frame after reset, %0d extra clocks", extra);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
